// File: rtl/clm_commit_collect_pkg.sv
// Shared types and default sizing for the per-column commit collector.
// Defaults match one TPU column of four rows and 8-bit MPU issue numbers.
package clm_commit_collect_pkg;

  localparam int CLM_NUM_ROWS   = 4;
  localparam int CLM_ISSUE_NO_W = 8;
  localparam int COMMIT_DEPTH   = 4;

  typedef logic [CLM_ISSUE_NO_W-1:0] mpu_issue_no_t;
  typedef logic [CLM_NUM_ROWS-1:0]   clm_mask_t;

  typedef struct packed {
    mpu_issue_no_t no;
    clm_mask_t     mask;
  } commit_ent_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_GAP   = 2'd2
  } commit_state_t;

endpackage

// File: rtl/clm_commit_collect_term_queue.sv
// One row's in-order queue of thread-termination nack bits.
// Push while full is dropped (caller flags it); pop while empty is ignored.
module commit_term_queue #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_push,
  input  logic i_dat,
  input  logic i_pop,
  output logic o_head,
  output logic o_empty,
  output logic o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_dat;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/clm_commit_collect.sv
// Per-column commit collector: records participating issues, pairs them with
// per-row in-order termination pulses, and emits one commit per issue in issue order.
module clm_commit_collect
  import clm_commit_collect_pkg::*;
#(
  parameter int NUM_ROWS   = CLM_NUM_ROWS,
  parameter int ISSUE_NO_W = CLM_ISSUE_NO_W,
  parameter int DEPTH      = COMMIT_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Req,
  input  logic [ISSUE_NO_W-1:0] I_Issue_No,
  input  logic [NUM_ROWS-1:0]   I_En_Exe,
  input  logic [NUM_ROWS-1:0]   I_Term,
  input  logic [NUM_ROWS-1:0]   I_Nack,
  output logic                  O_Commit_Req,
  output logic [ISSUE_NO_W-1:0] O_Commit_No,
  output logic                  O_Commit_Nack,
  input  logic                  I_Commit_Ack,
  output logic                  O_Full,
  output logic                  O_Err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [ISSUE_NO_W-1:0] no;
    logic [NUM_ROWS-1:0]   mask;
  } ent_t;

  ent_t          r_fifo [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  commit_state_t r_state;

  ent_t              w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_push_ok;
  logic              w_pop;
  logic              w_complete;
  logic              w_err_set;
  logic [CW-1:0]     w_cnt_nxt;
  logic [NUM_ROWS-1:0] w_q_head;
  logic [NUM_ROWS-1:0] w_q_empty;
  logic [NUM_ROWS-1:0] w_q_full;
  logic [NUM_ROWS-1:0] w_q_pop;

  assign w_head       = r_fifo[r_rp];
  assign w_fifo_full  = (r_cnt == CW'(DEPTH));
  assign w_fifo_empty = (r_cnt == '0);
  assign w_push       = I_Req & (|I_En_Exe);
  assign w_push_ok    = w_push & ~w_fifo_full;
  assign w_pop        = (r_state == ST_VALID) & I_Commit_Ack;
  assign w_cnt_nxt    = r_cnt + CW'(w_push_ok) - CW'(w_pop);
  // Head is complete once every participating row has a term waiting.
  assign w_complete   = ~w_fifo_empty & ((w_head.mask & w_q_empty) == '0);
  assign w_q_pop      = w_head.mask & {NUM_ROWS{w_pop}};
  assign w_err_set    = (w_push & w_fifo_full) | (|(I_Term & w_q_full));

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    commit_term_queue #(.DEPTH(DEPTH)) u_term_q (
      .clock   (clock),
      .reset   (reset),
      .i_push  (I_Term[g]),
      .i_dat   (I_Nack[g]),
      .i_pop   (w_q_pop[g]),
      .o_head  (w_q_head[g]),
      .o_empty (w_q_empty[g]),
      .o_full  (w_q_full[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      O_Full <= 1'b0;
      O_Err  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wp] <= '{no: I_Issue_No, mask: I_En_Exe};
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      r_cnt  <= w_cnt_nxt;
      O_Full <= (w_cnt_nxt == CW'(DEPTH));
      if (w_err_set) O_Err <= 1'b1;
    end
  end

  // GAP gives the pops one cycle to land before the next head is judged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      O_Commit_Req  <= 1'b0;
      O_Commit_No   <= '0;
      O_Commit_Nack <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_complete) begin
            O_Commit_No   <= w_head.no;
            O_Commit_Nack <= |(w_head.mask & w_q_head);
            O_Commit_Req  <= 1'b1;
            r_state       <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (I_Commit_Ack) begin
            O_Commit_Req <= 1'b0;
            r_state      <= ST_GAP;
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clm_commit_collect.sv
// Bench for clm_commit_collect: directed scenarios plus randomized traffic
// scored against an ordinal-based model of issue/term pairing.
module tb_clm_commit_collect;

  localparam int NR   = 4;
  localparam int IW   = 8;
  localparam int D    = 4;
  localparam int LOGN = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          I_Req = 1'b0;
  logic [IW-1:0] I_Issue_No = '0;
  logic [NR-1:0] I_En_Exe = '0;
  logic [NR-1:0] I_Term = '0;
  logic [NR-1:0] I_Nack = '0;
  logic          I_Commit_Ack = 1'b0;
  logic          O_Commit_Req;
  logic [IW-1:0] O_Commit_No;
  logic          O_Commit_Nack;
  logic          O_Full;
  logic          O_Err;

  always #5 clock = ~clock;

  clm_commit_collect #(.NUM_ROWS(NR), .ISSUE_NO_W(IW), .DEPTH(D)) dut (
    .clock         (clock),
    .reset         (reset),
    .I_Req         (I_Req),
    .I_Issue_No    (I_Issue_No),
    .I_En_Exe      (I_En_Exe),
    .I_Term        (I_Term),
    .I_Nack        (I_Nack),
    .O_Commit_Req  (O_Commit_Req),
    .O_Commit_No   (O_Commit_No),
    .O_Commit_Nack (O_Commit_Nack),
    .I_Commit_Ack  (I_Commit_Ack),
    .O_Full        (O_Full),
    .O_Err         (O_Err)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: each row's j-th accepted term belongs to the j-th accepted issue using that row.
  typedef struct {
    logic [IW-1:0] no;
    logic [NR-1:0] mask;
    int            ord [NR];
  } iss_t;

  iss_t iss_q[$];
  int   row_iss  [NR];
  int   row_term [NR];
  int   row_pop  [NR];
  bit   term_log [NR][LOGN];
  bit   exp_err;
  bit   seen_req;
  int   stall;

  task automatic model_clear();
    iss_q.delete();
    for (int r = 0; r < NR; r++) begin
      row_iss[r]  = 0;
      row_term[r] = 0;
      row_pop[r]  = 0;
    end
    exp_err  = 1'b0;
    seen_req = 1'b0;
    stall    = 0;
  endtask

  function automatic bit head_complete();
    iss_t h;
    if (iss_q.size() == 0) return 1'b0;
    h = iss_q[0];
    for (int r = 0; r < NR; r++)
      if (h.mask[r] && row_term[r] <= h.ord[r]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit head_nack();
    iss_t h;
    bit   n;
    n = 1'b0;
    if (iss_q.size() == 0) return 1'b0;
    h = iss_q[0];
    for (int r = 0; r < NR; r++)
      if (h.mask[r] && h.ord[r] < LOGN) n = n | term_log[r][h.ord[r]];
    return n;
  endfunction

  task automatic model_edge();
    bit   full_b;
    int   tq [NR];
    iss_t e;
    full_b = (iss_q.size() == D);
    for (int r = 0; r < NR; r++) tq[r] = row_term[r] - row_pop[r];
    if (I_Commit_Ack && seen_req && iss_q.size() > 0) begin
      e = iss_q.pop_front();
      for (int r = 0; r < NR; r++) if (e.mask[r]) row_pop[r]++;
    end
    if (I_Req && I_En_Exe != '0) begin
      if (full_b) exp_err = 1'b1;
      else begin
        e.no   = I_Issue_No;
        e.mask = I_En_Exe;
        for (int r = 0; r < NR; r++) begin
          e.ord[r] = row_iss[r];
          if (I_En_Exe[r]) row_iss[r]++;
        end
        iss_q.push_back(e);
      end
    end
    for (int r = 0; r < NR; r++) begin
      if (I_Term[r]) begin
        if (tq[r] >= D) exp_err = 1'b1;
        else begin
          if (row_term[r] < LOGN) term_log[r][row_term[r]] = I_Nack[r];
          row_term[r]++;
        end
      end
    end
  endtask

  task automatic check_cycle();
    check_val("full", 32'(O_Full), 32'(iss_q.size() == D));
    check_val("err", 32'(O_Err), 32'(exp_err));
    if (O_Commit_Req) begin
      check_val("req_head_complete", 32'(O_Commit_Req), 32'(head_complete()));
      if (iss_q.size() > 0) begin
        check_val("commit_no", 32'(O_Commit_No), 32'(iss_q[0].no));
        check_val("commit_nack", 32'(O_Commit_Nack), 32'(head_nack()));
      end
      stall = 0;
    end else begin
      if (head_complete()) stall++;
      else stall = 0;
      if (stall > 3) begin
        check_val("commit_timeout", 32'(O_Commit_Req), 32'd1);
        stall = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_cycle();
    seen_req = O_Commit_Req;
  endtask

  task automatic clr();
    I_Req = 1'b0; I_En_Exe = '0; I_Term = '0; I_Nack = '0; I_Commit_Ack = 1'b0;
  endtask

  task automatic issue(input logic [IW-1:0] no, input logic [NR-1:0] en);
    I_Req = 1'b1; I_Issue_No = no; I_En_Exe = en;
    tick();
    I_Req = 1'b0; I_En_Exe = '0;
  endtask

  task automatic term(input logic [NR-1:0] t, input logic [NR-1:0] n);
    I_Term = t; I_Nack = n;
    tick();
    I_Term = '0; I_Nack = '0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!O_Commit_Req && n < 30) begin tick(); n++; end
    check_val({tag, "_seen"}, 32'(O_Commit_Req), 32'd1);
  endtask

  task automatic wait_commit(input string tag, input logic [IW-1:0] no, input logic nack);
    wait_req(tag);
    if (O_Commit_Req) begin
      check_val({tag, "_no"}, 32'(O_Commit_No), 32'(no));
      check_val({tag, "_nack"}, 32'(O_Commit_Nack), 32'(nack));
    end
    I_Commit_Ack = 1'b1;
    tick();
    I_Commit_Ack = 1'b0;
    check_val({tag, "_drop"}, 32'(O_Commit_Req), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_val({tag, "_req"}, 32'(O_Commit_Req), 32'd0);
    check_val({tag, "_no"}, 32'(O_Commit_No), 32'd0);
    check_val({tag, "_nack"}, 32'(O_Commit_Nack), 32'd0);
    check_val({tag, "_full"}, 32'(O_Full), 32'd0);
    check_val({tag, "_err"}, 32'(O_Err), 32'd0);
    model_clear();
    clr();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] t, n;
    int            k;
    clr();
    model_clear();
    do_reset("rst0");

    // Single issue, exact latency from the last term.
    issue(8'h12, 4'b0101);
    term(4'b0001, 4'b0000);
    tick();
    tick();
    term(4'b0100, 4'b0000);
    check_val("lat_early", 32'(O_Commit_Req), 32'd0);
    tick();
    check_val("lat_req", 32'(O_Commit_Req), 32'd1);
    check_val("lat_no", 32'(O_Commit_No), 32'h12);
    check_val("lat_nack", 32'(O_Commit_Nack), 32'd0);
    I_Commit_Ack = 1'b1;
    tick();
    I_Commit_Ack = 1'b0;
    check_val("single_ack", 32'(O_Commit_Req), 32'd0);

    // Nack attribution and ordering.
    issue(8'h01, 4'b0011);
    issue(8'h02, 4'b0001);
    term(4'b0001, 4'b0000);
    term(4'b0001, 4'b0001);
    term(4'b0010, 4'b0000);
    wait_commit("ord1", 8'h01, 1'b0);
    wait_commit("ord2", 8'h02, 1'b1);

    // Zero mask is ignored.
    repeat (3) issue(8'h55, 4'b0000);
    repeat (6) tick();
    check_val("zero_req", 32'(O_Commit_Req), 32'd0);
    check_val("zero_full", 32'(O_Full), 32'd0);

    // Ack hold and gap to the next ready entry.
    issue(8'h30, 4'b0001);
    issue(8'h31, 4'b0001);
    term(4'b0001, 4'b0000);
    term(4'b0001, 4'b0001);
    wait_req("hold");
    repeat (10) begin
      tick();
      check_val("hold_req", 32'(O_Commit_Req), 32'd1);
      check_val("hold_no", 32'(O_Commit_No), 32'h30);
      check_val("hold_nack", 32'(O_Commit_Nack), 32'd0);
    end
    I_Commit_Ack = 1'b1;
    tick();
    I_Commit_Ack = 1'b0;
    check_val("hold_fall", 32'(O_Commit_Req), 32'd0);
    tick();
    check_val("hold_gap", 32'(O_Commit_Req), 32'd0);
    tick();
    check_val("hold_next_req", 32'(O_Commit_Req), 32'd1);
    check_val("hold_next_no", 32'(O_Commit_No), 32'h31);
    check_val("hold_next_nack", 32'(O_Commit_Nack), 32'd1);
    I_Commit_Ack = 1'b1;
    tick();
    I_Commit_Ack = 1'b0;

    // Full and overflow.
    for (int i = 0; i < D; i++) issue(8'h40 + 8'(i), 4'b0001);
    check_val("full_set", 32'(O_Full), 32'd1);
    check_val("full_noerr", 32'(O_Err), 32'd0);
    issue(8'h44, 4'b0001);
    check_val("ovf_err", 32'(O_Err), 32'd1);
    check_val("ovf_full", 32'(O_Full), 32'd1);
    for (int i = 0; i < D; i++) term(4'b0001, 4'b0000);
    for (int i = 0; i < D; i++) wait_commit("ovf", 8'h40 + 8'(i), 1'b0);
    repeat (8) tick();
    check_val("ovf_no_extra", 32'(O_Commit_Req), 32'd0);
    check_val("ovf_full_clr", 32'(O_Full), 32'd0);
    check_val("ovf_err_sticky", 32'(O_Err), 32'd1);

    // Reset while a commit is pending.
    issue(8'h60, 4'b0001);
    term(4'b0001, 4'b0000);
    wait_req("rst_pre");
    do_reset("rst_mid");
    term(4'b0001, 4'b0000);
    repeat (8) tick();
    check_val("rst_no_commit", 32'(O_Commit_Req), 32'd0);
    do_reset("rst_rand");

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      t = '0;
      n = '0;
      for (int r = 0; r < NR; r++) begin
        if ((row_term[r] - row_pop[r]) < D && $urandom_range(0, 2) == 0) begin
          t[r] = 1'b1;
          n[r] = ($urandom_range(0, 3) == 0);
        end
      end
      I_Term       = t;
      I_Nack       = n;
      I_Req        = ($urandom_range(0, 3) == 0) && (iss_q.size() < D);
      I_Issue_No   = 8'($urandom);
      I_En_Exe     = 4'($urandom_range(0, 15));
      I_Commit_Ack = seen_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      tick();
    end

    // Drain outstanding issues.
    clr();
    k = 0;
    while (iss_q.size() > 0 && k < 400) begin
      t = '0;
      for (int r = 0; r < NR; r++)
        if (row_term[r] < row_iss[r] && (row_term[r] - row_pop[r]) < D) t[r] = 1'b1;
      I_Term       = t;
      I_Nack       = '0;
      I_Commit_Ack = seen_req;
      tick();
      k++;
    end
    clr();
    check_val("drain_outstanding", 32'(iss_q.size()), 32'd0);
    tick();
    check_val("drain_full", 32'(O_Full), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/clm_commit_collect.md
Name: clm_commit_collect

Overview:
- Per-column commit collector. One instance per TPU column, between that column's TPUs and CommitAgg.
- Records every issue that enables at least one row of the column.
- Matches in-order per-row thread-termination pulses against recorded issues and emits one commit (issue number plus nack flag) per issue, strictly in issue order.
- Its O_Commit_* outputs drive CommitAgg's per-column commit inputs (TPU_CLM_Commit_Req/No).

Parameters:
- NUM_ROWS, 4, number of TPU rows in the column.
- ISSUE_NO_W, 8, width of the issue number (matches mpu_issue_no_t).
- DEPTH, 4, number of outstanding issues tracked; also the depth of each per-row term queue. Must be a power of two, at least 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- I_Req  in  1  issue strobe from MPU, one cycle per instruction issue.
- I_Issue_No  in  ISSUE_NO_W  issue number; valid with I_Req.
- I_En_Exe  in  NUM_ROWS  this column's slice of TPU_En_Exe; valid with I_Req.
- I_Term  in  NUM_ROWS  per-row thread-terminate pulse.
- I_Nack  in  NUM_ROWS  per-row abnormal-termination flag; sampled only where I_Term=1.
- O_Commit_Req  out  1  commit valid.
- O_Commit_No  out  ISSUE_NO_W  issue number being committed.
- O_Commit_Nack  out  1  1 = at least one enabled row nacked this issue.
- I_Commit_Ack  in  1  CommitAgg accepts the commit.
- O_Full  out  1  issue FIFO holds DEPTH entries.
- O_Err  out  1  sticky protocol error.

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers, count, per-row queues and error flag cleared.
  - O_Commit_Req=0, O_Commit_No=0, O_Commit_Nack=0, O_Full=0, O_Err=0.
  - All held until the first clock edge after release.
  - Reset mid-operation discards all pending entries; no commit is emitted for them.
- Issue FIFO: entries are {issue_no, mask}.
  - Push when I_Req=1 and I_En_Exe!=0.
  - I_Req with I_En_Exe=0 is ignored (column not participating).
  - Push while full is dropped and sets O_Err.
  - O_Full is registered and equals (count==DEPTH).
- Per-row term queue (DEPTH x 1 bit, stores the nack value):
  - I_Term[r]=1 pushes I_Nack[r] into queue r.
  - Push while queue r is full is dropped and sets O_Err.
  - Each row terminates threads in issue order; the term at queue head r belongs to the oldest issue whose mask has bit r.
- Completion: the head entry is complete when the FIFO is non-empty and queue r is non-empty for every r with mask[r]=1. Evaluated on registered state only.
- Commit state machine, states IDLE / VALID / GAP:
  - IDLE -> VALID when the head is complete. In the same edge, register O_Commit_No = head issue_no and O_Commit_Nack = OR of the queue-head nack bits over the mask rows, then set O_Commit_Req=1.
  - VALID: outputs held stable until I_Commit_Ack=1.
  - On ack: pop the FIFO head, pop queue r for every mask row, clear O_Commit_Req, go to GAP.
  - GAP -> IDLE after one cycle, so pointer updates settle; no combinational path from ack to the next request.
  - I_Commit_Ack while O_Commit_Req=0 is ignored.
- Latency:
  - Last required term sampled at edge t → O_Commit_Req=1 after edge t+1.
  - Back-to-back commits are at least 3 cycles apart (VALID, GAP, IDLE).
- Simultaneous events:
  - Issue push and commit pop in the same cycle: count unchanged, both take effect.
  - Term push and queue pop on the same row in the same cycle: both take effect, occupancy unchanged.
  - Terms for rows outside the head mask just accumulate for later entries.
- Arithmetic: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count fields are log2(DEPTH)+1 bits.
- O_Err is sticky until reset. It never blocks normal operation.

Decomposition:
- pkg_top holds:
  - typedef clm_mask_t = logic [NUM_ROWS-1:0];
  - struct commit_ent_t {mpu_issue_no_t no; clm_mask_t mask;}
  - constant COMMIT_DEPTH.
- One natural sub-module: commit_term_queue, a 1-bit-wide DEPTH-entry FIFO with push, pop, empty, full and head output. Instantiated NUM_ROWS times.
- The issue FIFO and commit FSM stay inline.

Test Plan:
- Reset mid-commit: O_Commit_Req=1 pending, drop reset → all outputs 0 immediately. After release, term on row 0 alone produces no commit.
- Single issue: I_Req, No=0x12, En=4'b0101; terms on row 0 at t and row 2 at t+3 → Commit_Req=1 after edge t+4 with No=0x12, Nack=0. Ack → Req=0 the next cycle.
- Nack and ordering: issues 0x01 (En=0011) and 0x02 (En=0001); row 0 terms twice, second with Nack=1; row 1 terms once → commit 0x01 Nack=0, then 0x02 Nack=1, in that order.
- Zero mask: I_Req with En=0000 → no FIFO push, O_Full unchanged, no commit ever.
- Full and overflow: 4 issues without terms → O_Full=1. A 5th issue → O_Err=1 and dropped. Completing all 4 → exactly 4 commits, O_Full=0.
- Ack hold: complete head, keep I_Commit_Ack=0 for 10 cycles → Req, No and Nack stable. Ack → a ready next entry appears 2 cycles after Req falls.
